// File: rtl/frame_bank_arbiter_pkg.sv
// frame_bank_arbiter_pkg: shared widths, FSM and read-source tag types for the frame bank arbiter.
package frame_bank_arbiter_pkg;
  localparam int ROW_W = 5;
  localparam int COL_W = 7;
  localparam int ADDR_W = 13;
  localparam logic [ADDR_W-1:0] BANK_OFFSET = 13'd4096;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } fsm_state_t;
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_ENG  = 2'd2
  } src_tag_t;
endpackage

// File: rtl/frame_bank_arbiter_read_return.sv
// fba_read_return: two-stage source tag pipeline that steers memory read data back to its requester.
module fba_read_return
  import frame_bank_arbiter_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  src_tag_t          tag_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic [DATA_W-1:0] disp_data_out,
  output logic              disp_valid_out,
  output logic [DATA_W-1:0] eng_data_out,
  output logic              eng_valid_out
);
  src_tag_t r_tag1, r_tag2;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_tag1 <= TAG_NONE;
      r_tag2 <= TAG_NONE;
    end else begin
      r_tag1 <= tag_in;
      r_tag2 <= r_tag1;
    end
  end
  // stage 2 lines up with the memory's one-cycle read latency after the registered address
  assign disp_valid_out = r_tag2 == TAG_DISP;
  assign eng_valid_out  = r_tag2 == TAG_ENG;
  assign disp_data_out  = disp_valid_out ? mem_rdata_in : '0;
  assign eng_data_out   = eng_valid_out ? mem_rdata_in : '0;
endmodule

// File: rtl/frame_bank_arbiter.sv
// frame_bank_arbiter: ping-pong frame memory arbiter between display scan-out and life-update engine,
// with the per-generation start/done/swap sequencer.
module frame_bank_arbiter
  import frame_bank_arbiter_pkg::*;
#(
  parameter int ROWS_W = 5,
  parameter int COLS_W = 7,
  parameter int DATA_W = 24,
  parameter int GEN_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              run_in,
  input  logic              vsync_in,
  input  logic              disp_req_in,
  input  logic [ROWS_W-1:0] disp_row_in,
  input  logic [COLS_W-1:0] disp_col_in,
  output logic [DATA_W-1:0] disp_data_out,
  output logic              disp_valid_out,
  input  logic              eng_rd_req_in,
  input  logic [ROWS_W-1:0] eng_rd_row_in,
  input  logic [COLS_W-1:0] eng_rd_col_in,
  output logic              eng_rd_gnt_out,
  output logic [DATA_W-1:0] eng_rd_data_out,
  output logic              eng_rd_valid_out,
  input  logic              eng_wr_req_in,
  input  logic [ROWS_W-1:0] eng_wr_row_in,
  input  logic [COLS_W-1:0] eng_wr_col_in,
  input  logic [DATA_W-1:0] eng_wr_data_in,
  output logic              eng_wr_gnt_out,
  input  logic              gen_done_in,
  output logic              gen_start_out,
  output logic              front_bank_out,
  output logic [GEN_W-1:0]  gen_count_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_we_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic [DATA_W-1:0] mem_rdata_in
);
  fsm_state_t        r_state;
  logic              r_front, r_start, r_we;
  logic [GEN_W-1:0]  r_gen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_run, w_wr_gnt, w_rd_gnt, w_bank, w_issue;
  logic [ROWS_W-1:0] w_row;
  logic [COLS_W-1:0] w_col;
  src_tag_t          w_tag;
  assign w_run    = (r_state == ST_RUN) && !rst_in;
  assign w_wr_gnt = w_run && eng_wr_req_in && !disp_req_in;
  assign w_rd_gnt = w_run && eng_rd_req_in && !disp_req_in && !eng_wr_req_in;
  assign w_issue  = disp_req_in || w_wr_gnt || w_rd_gnt;
  always_comb begin
    w_row  = disp_req_in ? disp_row_in : w_wr_gnt ? eng_wr_row_in : eng_rd_row_in;
    w_col  = disp_req_in ? disp_col_in : w_wr_gnt ? eng_wr_col_in : eng_rd_col_in;
    w_bank = w_wr_gnt ? ~r_front : r_front;
    w_tag  = disp_req_in ? TAG_DISP : w_rd_gnt ? TAG_ENG : TAG_NONE;
  end
  // the bank is latched with the address, so a swap never redirects an access already issued
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_front <= 1'b0;
      r_start <= 1'b0;
      r_gen   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_start <= 1'b0;
      r_we    <= w_wr_gnt;
      if (w_issue) r_addr <= (w_bank ? BANK_OFFSET : '0) | ADDR_W'({w_row, w_col});
      if (w_wr_gnt) r_wdata <= eng_wr_data_in;
      case (r_state)
        ST_IDLE: if (run_in) begin
          r_start <= 1'b1;
          r_state <= ST_RUN;
        end
        ST_RUN: if (gen_done_in) r_state <= ST_WAIT_SWAP;
        ST_WAIT_SWAP: if (vsync_in) begin
          r_front <= ~r_front;
          r_gen   <= r_gen + 1'b1;
          r_start <= run_in;
          r_state <= run_in ? ST_RUN : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign eng_wr_gnt_out = w_wr_gnt;
  assign eng_rd_gnt_out = w_rd_gnt;
  assign gen_start_out  = r_start;
  assign front_bank_out = r_front;
  assign gen_count_out  = r_gen;
  assign mem_addr_out   = r_addr;
  assign mem_we_out     = r_we;
  assign mem_wdata_out  = r_wdata;
  fba_read_return #(.DATA_W(DATA_W)) u_ret (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .tag_in         (w_tag),
    .mem_rdata_in   (mem_rdata_in),
    .disp_data_out  (disp_data_out),
    .disp_valid_out (disp_valid_out),
    .eng_data_out   (eng_rd_data_out),
    .eng_valid_out  (eng_rd_valid_out)
  );
endmodule

// File: tb/tb_frame_bank_arbiter.sv
// tb_frame_bank_arbiter: directed table-driven bench for frame_bank_arbiter with a behavioural memory.
module tb_frame_bank_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, run_in, vsync_in, gen_done_in;
  logic        disp_req_in, eng_rd_req_in, eng_wr_req_in;
  logic [4:0]  disp_row_in, eng_rd_row_in, eng_wr_row_in;
  logic [6:0]  disp_col_in, eng_rd_col_in, eng_wr_col_in;
  logic [23:0] eng_wr_data_in, disp_data_out, eng_rd_data_out, mem_wdata_out, mem_rdata_in;
  logic        disp_valid_out, eng_rd_gnt_out, eng_rd_valid_out, eng_wr_gnt_out;
  logic        gen_start_out, front_bank_out, mem_we_out;
  logic [15:0] gen_count_out;
  logic [12:0] mem_addr_out;
  logic [23:0] mem [0:8191];
  int n_tests = 0;
  int n_fail = 0;

  frame_bank_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .run_in(run_in), .vsync_in(vsync_in),
    .disp_req_in(disp_req_in), .disp_row_in(disp_row_in), .disp_col_in(disp_col_in),
    .disp_data_out(disp_data_out), .disp_valid_out(disp_valid_out),
    .eng_rd_req_in(eng_rd_req_in), .eng_rd_row_in(eng_rd_row_in), .eng_rd_col_in(eng_rd_col_in),
    .eng_rd_gnt_out(eng_rd_gnt_out), .eng_rd_data_out(eng_rd_data_out), .eng_rd_valid_out(eng_rd_valid_out),
    .eng_wr_req_in(eng_wr_req_in), .eng_wr_row_in(eng_wr_row_in), .eng_wr_col_in(eng_wr_col_in),
    .eng_wr_data_in(eng_wr_data_in), .eng_wr_gnt_out(eng_wr_gnt_out),
    .gen_done_in(gen_done_in), .gen_start_out(gen_start_out), .front_bank_out(front_bank_out),
    .gen_count_out(gen_count_out), .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out),
    .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (mem_we_out) mem[mem_addr_out] <= mem_wdata_out;
    mem_rdata_in <= mem[mem_addr_out];
  end

  typedef struct {
    logic d, w, r;
    logic [4:0] drow, wrow, rrow;
    logic [6:0] dcol, wcol, rcol;
    logic [23:0] wd;
    logic eg_w, eg_r;
    logic [12:0] ea;
    logic ewe;
    logic [23:0] ewd;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic clr;
    disp_req_in = 0; eng_rd_req_in = 0; eng_wr_req_in = 0;
    vsync_in = 0; gen_done_in = 0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[389] = 24'hABCDEF;
    mem[788] = 24'h123456;
    mem[384] = 24'h111111;
    mem[385] = 24'h222222;
    mem[386] = 24'h333333;
    vt[0] = '{1,1,1, 1,4,6, 1,10,20, 24'h0F0F0F, 0,0, 13'd129,  0, 24'h000000};
    vt[1] = '{0,1,1, 1,4,6, 1,10,20, 24'h0F0F0F, 1,0, 13'd4618, 1, 24'h0F0F0F};
    vt[2] = '{0,0,1, 1,4,6, 1,10,20, 24'h0F0F0F, 0,1, 13'd788,  0, 24'h0F0F0F};
    vt[3] = '{0,0,0, 1,4,6, 1,10,20, 24'h0F0F0F, 0,0, 13'd788,  0, 24'h0F0F0F};
    vt[4] = '{0,1,0, 0,31,0, 0,127,0, 24'hA5A5A5, 1,0, 13'd8191, 1, 24'hA5A5A5};
    vt[5] = '{1,0,0, 31,0,0, 127,0,0, 24'h5A5A5A, 0,0, 13'd4095, 0, 24'hA5A5A5};
    vt[6] = '{0,0,1, 0,0,0, 0,0,0, 24'h5A5A5A, 0,1, 13'd0, 0, 24'hA5A5A5};
    clr();
    disp_row_in = 0; disp_col_in = 0; eng_rd_row_in = 0; eng_rd_col_in = 0;
    eng_wr_row_in = 0; eng_wr_col_in = 0; eng_wr_data_in = 24'hFFFFFF;
    // reset with requests active: nothing may be granted or returned
    rst_in = 1; run_in = 1; disp_req_in = 1; eng_wr_req_in = 1; eng_rd_req_in = 1;
    repeat (3) tick();
    chk("rst_wr_gnt", eng_wr_gnt_out, 0);
    chk("rst_rd_gnt", eng_rd_gnt_out, 0);
    chk("rst_gen_start", gen_start_out, 0);
    chk("rst_front", front_bank_out, 0);
    chk("rst_count", gen_count_out, 0);
    chk("rst_we", mem_we_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_wdata", mem_wdata_out, 0);
    chk("rst_disp_valid", disp_valid_out, 0);
    chk("rst_disp_data", disp_data_out, 0);
    chk("rst_eng_valid", eng_rd_valid_out, 0);
    clr(); run_in = 0; rst_in = 0;
    tick();
    chk("idle_no_start", gen_start_out, 0);
    run_in = 1;
    tick();
    chk("start_pulse", gen_start_out, 1);
    chk("start_front", front_bank_out, 0);
    tick();
    chk("start_one_cycle", gen_start_out, 0);
    chk("no_we_before_write", mem_we_out, 0);
    // display read row 3 col 5
    disp_req_in = 1; disp_row_in = 3; disp_col_in = 5;
    tick();
    disp_req_in = 0;
    chk("disp_addr", mem_addr_out, 389);
    chk("disp_we", mem_we_out, 0);
    chk("disp_early_valid", disp_valid_out, 0);
    tick();
    chk("disp_valid", disp_valid_out, 1);
    chk("disp_data", disp_data_out, 24'hABCDEF);
    chk("disp_not_eng", eng_rd_valid_out, 0);
    // arbitration table
    for (int i = 0; i < 7; i++) begin
      disp_req_in = vt[i].d; eng_wr_req_in = vt[i].w; eng_rd_req_in = vt[i].r;
      disp_row_in = vt[i].drow; disp_col_in = vt[i].dcol;
      eng_wr_row_in = vt[i].wrow; eng_wr_col_in = vt[i].wcol; eng_wr_data_in = vt[i].wd;
      eng_rd_row_in = vt[i].rrow; eng_rd_col_in = vt[i].rcol;
      #1;
      chk($sformatf("v%0d_wr_gnt", i), eng_wr_gnt_out, vt[i].eg_w);
      chk($sformatf("v%0d_rd_gnt", i), eng_rd_gnt_out, vt[i].eg_r);
      tick();
      chk($sformatf("v%0d_addr", i), mem_addr_out, vt[i].ea);
      chk($sformatf("v%0d_we", i), mem_we_out, vt[i].ewe);
      chk($sformatf("v%0d_wdata", i), mem_wdata_out, vt[i].ewd);
    end
    clr();
    repeat (2) tick();
    // engine read returns on the engine port only, two cycles after grant
    eng_rd_req_in = 1; eng_rd_row_in = 6; eng_rd_col_in = 20;
    #1;
    chk("erd_gnt", eng_rd_gnt_out, 1);
    tick();
    eng_rd_req_in = 0;
    chk("erd_early_valid", eng_rd_valid_out, 0);
    tick();
    chk("erd_valid", eng_rd_valid_out, 1);
    chk("erd_data", eng_rd_data_out, 24'h123456);
    chk("erd_not_disp", disp_valid_out, 0);
    tick();
    // back-to-back display reads at full throughput
    for (int k = 0; k < 5; k++) begin
      disp_req_in = (k < 3); disp_row_in = 3; disp_col_in = 7'(k);
      #1;
      if (k >= 2) begin
        chk($sformatf("burst%0d_valid", k), disp_valid_out, 1);
        chk($sformatf("burst%0d_data", k), disp_data_out, 24'h111111 * (k - 1));
      end
      tick();
    end
    clr();
    chk("burst_end_valid", disp_valid_out, 0);
    // vsync outside WAIT_SWAP is ignored
    vsync_in = 1;
    tick();
    vsync_in = 0;
    chk("vsync_run_front", front_bank_out, 0);
    chk("vsync_run_count", gen_count_out, 0);
    // done then vsync 10 cycles later
    gen_done_in = 1;
    tick();
    gen_done_in = 0;
    eng_wr_req_in = 1; eng_wr_row_in = 0; eng_wr_col_in = 5; eng_wr_data_in = 24'h00C0DE;
    #1;
    chk("wait_no_wr_gnt", eng_wr_gnt_out, 0);
    repeat (9) tick();
    chk("wait_front_hold", front_bank_out, 0);
    vsync_in = 1;
    tick();
    vsync_in = 0;
    chk("swap_front", front_bank_out, 1);
    chk("swap_count", gen_count_out, 1);
    chk("swap_start", gen_start_out, 1);
    #1;
    chk("swap_wr_gnt", eng_wr_gnt_out, 1);
    tick();
    eng_wr_req_in = 0;
    chk("swap_wr_addr", mem_addr_out, 5);
    chk("swap_wr_we", mem_we_out, 1);
    chk("swap_start_cleared", gen_start_out, 0);
    // done and vsync together: swap waits for the next vsync
    gen_done_in = 1; vsync_in = 1;
    tick();
    clr();
    chk("same_front", front_bank_out, 1);
    chk("same_count", gen_count_out, 1);
    chk("same_start", gen_start_out, 0);
    repeat (3) tick();
    vsync_in = 1;
    tick();
    vsync_in = 0;
    chk("late_front", front_bank_out, 0);
    chk("late_count", gen_count_out, 2);
    chk("late_start", gen_start_out, 1);
    // run drop: finish generation, swap, then park in IDLE
    run_in = 0;
    tick();
    gen_done_in = 1;
    tick();
    gen_done_in = 0; vsync_in = 1;
    tick();
    vsync_in = 0;
    chk("stop_front", front_bank_out, 1);
    chk("stop_count", gen_count_out, 3);
    chk("stop_start", gen_start_out, 0);
    eng_wr_req_in = 1;
    #1;
    chk("idle_no_wr_gnt", eng_wr_gnt_out, 0);
    eng_wr_req_in = 0;
    run_in = 1;
    tick();
    chk("restart_start", gen_start_out, 1);
    // reset one cycle after an engine read grant drops the return
    eng_rd_req_in = 1; eng_rd_row_in = 2; eng_rd_col_in = 2;
    #1;
    chk("pre_rst_rd_gnt", eng_rd_gnt_out, 1);
    tick();
    eng_rd_req_in = 0; rst_in = 1; run_in = 0;
    tick();
    rst_in = 0;
    chk("midrst_eng_valid", eng_rd_valid_out, 0);
    chk("midrst_front", front_bank_out, 0);
    chk("midrst_count", gen_count_out, 0);
    chk("midrst_addr", mem_addr_out, 0);
    chk("midrst_we", mem_we_out, 0);
    chk("midrst_start", gen_start_out, 0);
    chk("midrst_disp_valid", disp_valid_out, 0);
    tick();
    chk("midrst_eng_valid2", eng_rd_valid_out, 0);
    chk("midrst_eng_data", eng_rd_data_out, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_bank_arbiter.md
# frame_bank_arbiter

Shares the single-port 8192×24 frame memory between the display scan-out reader and the life-update engine. It runs the ping-pong bank scheme: the front bank is displayed and read as the current generation, and the back bank receives the next generation. The block sequences each generation (start, done, swap on vertical sync) and sits between the memory macro and its two clients.

## Interface
Parameters:
- ROWS_W, 5, row-index width (32 rows)
- COLS_W, 7, column-index width (128 words per row)
- DATA_W, 24, word width (24 cells per word)
- GEN_W, 16, generation counter width

Ports (one clock, `clk_in`; reset `rst_in` is synchronous and active-high):
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- run_in  in  1  level; enables generation stepping
- vsync_in  in  1  one-cycle pulse at the frame boundary
- disp_req_in  in  1  display read request, one word per cycle
- disp_row_in  in  ROWS_W  display row
- disp_col_in  in  COLS_W  display column
- disp_data_out  out  DATA_W  display read data
- disp_valid_out  out  1  display data valid
- eng_rd_req_in  in  1  engine read request (front bank)
- eng_rd_row_in / eng_rd_col_in  in  ROWS_W / COLS_W  engine read address
- eng_rd_gnt_out  out  1  engine read accepted this cycle (combinational)
- eng_rd_data_out  out  DATA_W  engine read data
- eng_rd_valid_out  out  1  engine read data valid
- eng_wr_req_in  in  1  engine write request (back bank)
- eng_wr_row_in / eng_wr_col_in  in  ROWS_W / COLS_W  engine write address
- eng_wr_data_in  in  DATA_W  engine write data
- eng_wr_gnt_out  out  1  engine write accepted this cycle (combinational)
- gen_done_in  in  1  pulse; engine finished the current generation
- gen_start_out  out  1  pulse; engine may begin a generation
- front_bank_out  out  1  bank currently displayed
- gen_count_out  out  GEN_W  completed swaps, wraps modulo 2^GEN_W
- mem_addr_out  out  13  {bank, row, col}
- mem_we_out  out  1  write enable
- mem_wdata_out  out  DATA_W  write data
- mem_rdata_in  in  DATA_W  read data, one cycle after the address

## Operation
- Address mapping is bank×4096 + row×128 + col. Bank 1 starts at 4096.
- Per-cycle fixed priority is display > engine write > engine read. Exactly one access or none is issued per cycle.
- Engine requests are granted only in RUN. A requester holds its request, address and data stable until it is granted.
- Display and engine reads use the front bank. Engine writes use the back bank (~front_bank).
- A 2-stage source tag (none/disp/eng) follows each read, so returned data goes only to its originator.
- FSM states:
  - IDLE: if run_in, pulse gen_start_out and go to RUN.
  - RUN: on gen_done_in, go to WAIT_SWAP.
  - WAIT_SWAP: on vsync_in, toggle front_bank, increment gen_count, then pulse gen_start_out and go to RUN if run_in, else go to IDLE.
- vsync_in is ignored outside WAIT_SWAP. gen_done_in is ignored outside RUN.
- gen_done_in and vsync_in in the same RUN cycle: go to WAIT_SWAP. The swap waits for the next vsync.
- run_in dropping during RUN does not abort the generation. The FSM stops in IDLE after the next swap.

## Timing
- Grant cycle N: mem_addr/we/wdata are registered and valid in N+1. Read data is valid in N+2.
- disp_valid_out asserts 2 cycles after disp_req_in, and keeps asserting every cycle at full throughput.
- eng_rd_valid_out asserts 2 cycles after eng_rd_gnt_out.
- gen_start_out is high for exactly one cycle, registered, in the cycle after the IDLE or WAIT_SWAP transition decision.
- front_bank_out changes in the cycle after the vsync_in sample. Reads already in flight keep their issued bank.
- Reset values: FSM=IDLE, front_bank_out=0, gen_count_out=0. All valids, gnts, gen_start_out and mem_we_out are 0. mem_addr_out=0, mem_wdata_out=0, data outputs=0. The tag pipeline is cleared.
- Reset mid-operation drops all in-flight reads: no valid pulses after reset.

## Structure
- The shared package holds the FSM state enum, the source-tag enum, BANK_OFFSET=4096, and the row/col/addr width constants.
- One sub-module, `fba_read_return`: the 2-stage tag pipeline plus the data steering to the disp/eng outputs.

## Test plan
- Reset, then run_in=1: gen_start_out pulses once, front_bank_out=0, and the FSM is in RUN. No mem_we_out before an engine write.
- Display reads row 3 col 5 with mem_rdata_in=0xABCDEF: mem_addr_out=389 one cycle later, and disp_data_out=0xABCDEF with valid two cycles after the request.
- disp_req, eng_wr and eng_rd all asserted together: the display is served first, then the write (mem_addr=4096+row×128+col, we=1), then the read. Each grant comes on a separate cycle.
- Sequence gen_done_in, then vsync_in 10 cycles later: front_bank_out becomes 1, gen_count_out=1, and gen_start_out pulses. Engine writes now target addresses 0..4095.
- gen_done_in and vsync_in in the same cycle: no swap. The swap happens on the next vsync_in.
- rst_in asserted one cycle after an engine read grant: no eng_rd_valid_out follows, and all outputs return to their reset values.
